// File: rtl/mem_access_stage_pkg.sv
// Shared RISC-V definitions for the MEM stage: opcodes, funct3 size codes and FSM state encoding.
// The access-size helper decodes funct3 into byte, halfword or word.
package mem_access_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Unlisted funct3 codes fall through to a word access.
    function automatic acc_size_t access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load alignment: picks the byte/halfword lane of the read word
// and applies sign or zero extension according to funct3.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_WIDTH-1:0] rdata,
    input  logic [1:0]           byte_off,
    input  logic [2:0]           funct3,
    output logic [REG_WIDTH-1:0] data
);

    localparam int LANES = REG_WIDTH / 8;

    logic [7:0]  lane [LANES];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane[gi] = rdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        sel_b = lane[byte_off];
        sel_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'b0, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'b0, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: ready-handshake data-memory access with wait/timeout FSM and MEM/WB register.
// Optional misaligned-access trapping is enabled by defining MISALIGN_CHECK_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DMEM_TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
    input  logic [6:0]                EX_MEM_inst_opcode,
    input  logic [2:0]                EX_MEM_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      EX_MEM_reg_write_en,
    input  logic                      EX_MEM_mem_write_en,
    input  logic                      EX_MEM_wb_sel,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [REG_WIDTH-1:0]      dmem_addr,
    output logic [REG_WIDTH-1:0]      dmem_wdata,
    output logic [REG_WIDTH/8-1:0]    dmem_wstrb,
    input  logic                      dmem_ready,
    input  logic [REG_WIDTH-1:0]      dmem_rdata,
    output logic                      mem_stall,
    output logic [REG_WIDTH-1:0]      MEM_WB_alu_out,
    output logic [REG_WIDTH-1:0]      MEM_WB_mem_data,
    output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
    output logic                      MEM_WB_reg_write_en,
    output logic                      MEM_WB_wb_sel,
    output logic                      mem_err,
    output logic                      mem_misalign
);

    localparam int LANES = REG_WIDTH / 8;
    localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            access;
    logic            is_store;
    logic            misalign_hit;
    logic            eff_access;
    acc_size_t       size;
    logic [1:0]      off;

    mem_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic            at_limit;
    logic            timeout;
    logic            req_int;
    logic            stall_int;

    logic [LANES-1:0]     strb_next;
    logic [REG_WIDTH-1:0] load_data;

    assign is_store = (EX_MEM_inst_opcode == OPC_STORE);
    assign access   = (EX_MEM_inst_opcode == OPC_LOAD) || is_store;
    assign size     = access_size(EX_MEM_funct3);
    assign off      = EX_MEM_alu_out[1:0];

`ifdef MISALIGN_CHECK_EN
    assign misalign_hit = access && (((size == SZ_HALF) && off[0]) ||
                                     ((size == SZ_WORD) && (off != 2'b00)));
`else
    assign misalign_hit = 1'b0;
`endif

    // A trapped misaligned access never reaches memory or the FSM.
    assign eff_access = access && !misalign_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (eff_access && !dmem_ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (!eff_access || dmem_ready || timeout) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // At the limit the request drops; a late ready in that cycle still completes.
    always_comb begin
        at_limit  = (state_reg == ST_WAIT) && (cnt_reg == CNT_MAX);
        timeout   = eff_access && at_limit && !dmem_ready;
        req_int   = eff_access && !at_limit;
        stall_int = eff_access && !dmem_ready && !timeout;
    end

    always_comb begin
        strb_next  = '0;
        dmem_wdata = EX_MEM_dataB;
        case (size)
            SZ_BYTE: begin
                strb_next  = 4'b0001 << off;
                dmem_wdata = {4{EX_MEM_dataB[7:0]}};
            end
            SZ_HALF: begin
                strb_next  = 4'b0011 << {off[1], 1'b0};
                dmem_wdata = {2{EX_MEM_dataB[15:0]}};
            end
            default: strb_next = 4'b1111;
        endcase
    end

    assign dmem_req   = req_int && reset_n;
    assign dmem_we    = eff_access && EX_MEM_mem_write_en && reset_n;
    assign dmem_wstrb = (is_store && eff_access && reset_n) ? strb_next : '0;
    assign dmem_addr  = {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
    assign mem_stall  = stall_int && reset_n;

    mem_access_stage_load_align #(
        .REG_WIDTH (REG_WIDTH)
    ) u_load_align (
        .rdata    (dmem_rdata),
        .byte_off (off),
        .funct3   (EX_MEM_funct3),
        .data     (load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MEM_WB_alu_out      <= '0;
            MEM_WB_mem_data     <= '0;
            MEM_WB_rd           <= '0;
            MEM_WB_reg_write_en <= 1'b0;
            MEM_WB_wb_sel       <= 1'b0;
            mem_err             <= 1'b0;
        end else begin
            if (stall_int) begin
                MEM_WB_reg_write_en <= 1'b0;
            end else begin
                MEM_WB_alu_out      <= EX_MEM_alu_out;
                MEM_WB_mem_data     <= load_data;
                MEM_WB_rd           <= EX_MEM_rd;
                MEM_WB_reg_write_en <= EX_MEM_reg_write_en && !timeout && !misalign_hit;
                MEM_WB_wb_sel       <= EX_MEM_wb_sel;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic misalign_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_hit;
        end
    end

    assign mem_misalign = misalign_reg;
`else
    assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// loads/stores against an arithmetic reference model of the alignment rules.
module tb_mem_access_stage;

    localparam int TMO = 4;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;
    localparam logic [6:0] JAL   = 7'b1101111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] EX_MEM_alu_out, EX_MEM_dataB;
    logic [6:0]  EX_MEM_inst_opcode;
    logic [2:0]  EX_MEM_funct3;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_reg_write_en, EX_MEM_mem_write_en, EX_MEM_wb_sel;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] MEM_WB_alu_out, MEM_WB_mem_data;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_reg_write_en, MEM_WB_wb_sel;
    logic        mem_err, mem_misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .REG_WIDTH(32), .REG_ADDR_WIDTH(5), .DMEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_dataB(EX_MEM_dataB),
        .EX_MEM_inst_opcode(EX_MEM_inst_opcode), .EX_MEM_funct3(EX_MEM_funct3),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write_en(EX_MEM_reg_write_en),
        .EX_MEM_mem_write_en(EX_MEM_mem_write_en), .EX_MEM_wb_sel(EX_MEM_wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .MEM_WB_alu_out(MEM_WB_alu_out), .MEM_WB_mem_data(MEM_WB_mem_data),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write_en(MEM_WB_reg_write_en),
        .MEM_WB_wb_sel(MEM_WB_wb_sel),
        .mem_err(mem_err), .mem_misalign(mem_misalign)
    );

    // ---------------- reference model ----------------
    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 0;
        if (f3 == 3'd1 || f3 == 3'd5) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        logic [31:0] v;
        case (sz(f3))
            0: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            1: begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input int off);
        int s;
        case (sz(f3))
            0:       s = 1 << off;
            1:       s = 3 << (2 * (off / 2));
            default: s = 15;
        endcase
        return s[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] b);
        case (sz(f3))
            0:       return (b & 32'hFF) * 32'h01010101;
            1:       return (b & 32'hFFFF) * 32'h00010001;
            default: return b;
        endcase
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input int off);
`ifdef MISALIGN_CHECK_EN
        if (sz(f3) == 1) return (off % 2) != 0;
        if (sz(f3) == 2) return off != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_ex(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] b, input logic [4:0] rd, input logic rwe,
                          input logic mwe, input logic wbs);
        EX_MEM_inst_opcode  = opc;
        EX_MEM_funct3       = f3;
        EX_MEM_alu_out      = addr;
        EX_MEM_dataB        = b;
        EX_MEM_rd           = rd;
        EX_MEM_reg_write_en = rwe;
        EX_MEM_mem_write_en = mwe;
        EX_MEM_wb_sel       = wbs;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        set_ex(STORE, 3'd2, 32'h10, 32'h55, 5'd3, 1'b1, 1'b1, 1'b0);
        tick;
        tick;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", dmem_we); end
        total++; if (dmem_wstrb !== 4'h0) begin bad++; $display("FAIL reset_wstrb got=%h exp=0", dmem_wstrb); end
        total++; if (MEM_WB_reg_write_en !== 1'b0) begin bad++; $display("FAIL reset_regwe got=%b exp=0", MEM_WB_reg_write_en); end
        total++; if (MEM_WB_alu_out !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", MEM_WB_alu_out); end
        total++; if (mem_err !== 1'b0 || mem_misalign !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", mem_err, mem_misalign); end
        set_ex(ALU, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick;
        $display("txn reset done");
    endtask

    task automatic test_lw;
        set_ex(LOAD, 3'd2, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL lw_stall got=%b exp=0", mem_stall); end
        total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin bad++; $display("FAIL lw_req got=%b/%h exp=1/100", dmem_req, dmem_addr); end
        total++; if (dmem_wstrb !== 4'h0 || dmem_we !== 1'b0) begin bad++; $display("FAIL lw_strb got=%h/%b exp=0/0", dmem_wstrb, dmem_we); end
        tick;
        total++; if (MEM_WB_mem_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", MEM_WB_mem_data); end
        total++; if (MEM_WB_reg_write_en !== 1'b1 || MEM_WB_rd !== 5'd5) begin bad++; $display("FAIL lw_wb got=%b/%0d exp=1/5", MEM_WB_reg_write_en, MEM_WB_rd); end
        $display("txn LW 0x100 zero-wait");
    endtask

    task automatic test_lb_wait;
        set_ex(LOAD, 3'd0, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 32'h80112233;
        for (int c = 0; c <= 2; c++) begin
            dmem_ready = (c == 2);
            #1;
            total++; if (mem_stall !== (c < 2)) begin bad++; $display("FAIL lb_stall c=%0d got=%b exp=%b", c, mem_stall, c < 2); end
            tick;
            if (c < 2) begin
                total++; if (MEM_WB_reg_write_en !== 1'b0) begin bad++; $display("FAIL lb_bubble c=%0d got=%b exp=0", c, MEM_WB_reg_write_en); end
            end
        end
        total++; if (MEM_WB_mem_data !== 32'hFFFFFF80 || MEM_WB_reg_write_en !== 1'b1) begin bad++; $display("FAIL lb_data got=%h/%b exp=ffffff80/1", MEM_WB_mem_data, MEM_WB_reg_write_en); end
        $display("txn LB 0x103 wait=2");
    endtask

    task automatic test_sh;
        set_ex(STORE, 3'd1, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        #1;
        total++; if (dmem_addr !== 32'h200) begin bad++; $display("FAIL sh_addr got=%h exp=200", dmem_addr); end
        total++; if (dmem_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_strb got=%b exp=1100", dmem_wstrb); end
        total++; if (dmem_wdata !== 32'hABCDABCD || dmem_we !== 1'b1) begin bad++; $display("FAIL sh_wdata got=%h/%b exp=abcdabcd/1", dmem_wdata, dmem_we); end
        tick;
        total++; if (MEM_WB_reg_write_en !== 1'b0) begin bad++; $display("FAIL sh_regwe got=%b exp=0", MEM_WB_reg_write_en); end
        $display("txn SH 0x202");
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        set_ex(LOAD, 3'd2, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b0;
        for (int c = 0; c <= TMO; c++) begin
            #1;
            if (dmem_req === 1'b1) req_cycles++;
            total++; if (mem_stall !== (c < TMO)) begin bad++; $display("FAIL tmo_stall c=%0d got=%b exp=%b", c, mem_stall, c < TMO); end
            tick;
            total++; if (MEM_WB_reg_write_en !== 1'b0) begin bad++; $display("FAIL tmo_regwe c=%0d got=%b exp=0", c, MEM_WB_reg_write_en); end
        end
        total++; if (req_cycles != TMO) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", req_cycles, TMO); end
        total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", mem_err); end
        set_ex(ALU, 3'd0, 32'h1234, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL alu_req got=%b/%b exp=0/0", dmem_req, mem_stall); end
        tick;
        total++; if (mem_err !== 1'b1 || MEM_WB_reg_write_en !== 1'b1 || MEM_WB_alu_out !== 32'h1234) begin bad++; $display("FAIL tmo_sticky got=%b/%b/%h exp=1/1/1234", mem_err, MEM_WB_reg_write_en, MEM_WB_alu_out); end
        $display("txn LW 0x300 timeout");
    endtask

    task automatic test_reset_in_wait;
        set_ex(LOAD, 3'd2, 32'h400, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b0;
        tick;
        tick;
        total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL rw_stall got=%b exp=1", mem_stall); end
        reset_n = 1'b0;
        #1;
        total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL rw_outs got=%b/%b/%b exp=0/0/0", dmem_req, mem_stall, dmem_we); end
        total++; if (mem_err !== 1'b0 || MEM_WB_reg_write_en !== 1'b0 || MEM_WB_alu_out !== 32'h0) begin bad++; $display("FAIL rw_regs got=%b/%b/%h exp=0/0/0", mem_err, MEM_WB_reg_write_en, MEM_WB_alu_out); end
        tick;
        reset_n = 1'b1;
        set_ex(LOAD, 3'd2, 32'h404, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        total++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin bad++; $display("FAIL rw_next got=%b/%b exp=0/1", mem_stall, dmem_req); end
        tick;
        total++; if (MEM_WB_mem_data !== 32'hCAFEF00D || MEM_WB_reg_write_en !== 1'b1 || MEM_WB_rd !== 5'd12) begin bad++; $display("FAIL rw_wb got=%h/%b/%0d exp=cafef00d/1/12", MEM_WB_mem_data, MEM_WB_reg_write_en, MEM_WB_rd); end
        $display("txn reset during WAIT");
    endtask

    task automatic test_misalign;
        set_ex(LOAD, 3'd2, 32'h102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h11223344;
        #1;
`ifdef MISALIGN_CHECK_EN
        total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL mis_req got=%b/%b exp=0/0", dmem_req, mem_stall); end
        tick;
        total++; if (mem_misalign !== 1'b1 || MEM_WB_reg_write_en !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b/%b exp=1/0", mem_misalign, MEM_WB_reg_write_en); end
        set_ex(ALU, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick;
        total++; if (mem_misalign !== 1'b0) begin bad++; $display("FAIL mis_once got=%b exp=0", mem_misalign); end
`else
        total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin bad++; $display("FAIL mis_req got=%b/%h exp=1/100", dmem_req, dmem_addr); end
        tick;
        total++; if (MEM_WB_mem_data !== 32'h11223344 || MEM_WB_reg_write_en !== 1'b1 || mem_misalign !== 1'b0) begin bad++; $display("FAIL mis_data got=%h/%b/%b exp=11223344/1/0", MEM_WB_mem_data, MEM_WB_reg_write_en, mem_misalign); end
`endif
        $display("txn LW 0x102 misalign");
    endtask

    task automatic run_random(input int n, input int max_wait, input string tag);
        logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < n; i++) begin
            int          kind = $urandom_range(0, 3);
            logic [6:0]  opc;
            logic [2:0]  f3;
            logic [31:0] addr = $urandom;
            logic [31:0] b    = $urandom;
            logic [31:0] rdv  = $urandom;
            logic [4:0]  rd   = 5'($urandom_range(0, 31));
            logic        rwe  = 1'($urandom_range(0, 1));
            logic        wbs  = 1'($urandom_range(0, 1));
            int          off  = int'(addr[1:0]);
            logic        acc, mis, ld;
            int          w;
            case (kind)
                0: begin opc = LOAD;  f3 = lf3[$urandom_range(0, 4)]; end
                1: begin opc = STORE; f3 = 3'($urandom_range(0, 2)); end
                2: begin opc = ALU;   f3 = 3'($urandom_range(0, 7)); end
                default: begin opc = JAL; f3 = 3'($urandom_range(0, 7)); end
            endcase
            acc = (kind < 2);
            ld  = (kind == 0);
            mis = acc && is_mis(f3, off);
            w   = (acc && !mis) ? $urandom_range(0, max_wait) : 0;
            set_ex(opc, f3, addr, b, rd, rwe, (kind == 1), wbs);
            dmem_rdata = rdv;
            for (int c = 0; c <= w; c++) begin
                dmem_ready = (c == w);
                #1;
                total++; if (dmem_req !== (acc && !mis)) begin bad++; $display("FAIL %s_req i=%0d got=%b exp=%b", tag, i, dmem_req, acc && !mis); end
                total++; if (mem_stall !== (c < w)) begin bad++; $display("FAIL %s_stall i=%0d got=%b exp=%b", tag, i, mem_stall, c < w); end
                if (c == 0 && acc && !mis) begin
                    total++; if (dmem_addr !== (addr & 32'hFFFFFFFC)) begin bad++; $display("FAIL %s_addr i=%0d got=%h exp=%h", tag, i, dmem_addr, addr & 32'hFFFFFFFC); end
                    total++; if (dmem_wstrb !== (ld ? 4'h0 : exp_strb(f3, off))) begin bad++; $display("FAIL %s_strb i=%0d got=%b exp=%b", tag, i, dmem_wstrb, ld ? 4'h0 : exp_strb(f3, off)); end
                    total++; if (dmem_we !== !ld) begin bad++; $display("FAIL %s_we i=%0d got=%b exp=%b", tag, i, dmem_we, !ld); end
                    if (!ld) begin
                        total++; if (dmem_wdata !== exp_wdata(f3, b)) begin bad++; $display("FAIL %s_wdata i=%0d got=%h exp=%h", tag, i, dmem_wdata, exp_wdata(f3, b)); end
                    end
                end
                tick;
                if (c < w) begin
                    total++; if (MEM_WB_reg_write_en !== 1'b0) begin bad++; $display("FAIL %s_bubble i=%0d got=%b exp=0", tag, i, MEM_WB_reg_write_en); end
                end
            end
            total++; if (MEM_WB_reg_write_en !== (rwe && !mis)) begin bad++; $display("FAIL %s_regwe i=%0d got=%b exp=%b", tag, i, MEM_WB_reg_write_en, rwe && !mis); end
            total++; if (MEM_WB_alu_out !== addr || MEM_WB_rd !== rd || MEM_WB_wb_sel !== wbs) begin bad++; $display("FAIL %s_fields i=%0d got=%h/%0d/%b exp=%h/%0d/%b", tag, i, MEM_WB_alu_out, MEM_WB_rd, MEM_WB_wb_sel, addr, rd, wbs); end
            total++; if (mem_misalign !== mis) begin bad++; $display("FAIL %s_misalign i=%0d got=%b exp=%b", tag, i, mem_misalign, mis); end
            if (ld && !mis) begin
                total++; if (MEM_WB_mem_data !== exp_load(f3, off, rdv)) begin bad++; $display("FAIL %s_ldata i=%0d got=%h exp=%h", tag, i, MEM_WB_mem_data, exp_load(f3, off, rdv)); end
            end
            $display("txn %s %0d opc=%h f3=%0d addr=%h wait=%0d", tag, i, opc, f3, addr, w);
        end
    endtask

    task automatic test_random;
        run_random(60, TMO - 1, "rand");
    endtask

    task automatic test_back_to_back;
        run_random(12, 0, "b2b");
        total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", mem_err); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb_wait;
        test_sh;
        test_timeout;
        test_reset_in_wait;
        test_misalign;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
